// File: rtl/lif_cfg_pkg.sv
// Shared definitions for the LIF neuron serial configuration path:
// transmitter state encoding, default frame width and the frame field layout.
package lif_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_WAIT_READY = 2'd2
  } cfg_state_e;

  localparam int DEFAULT_FRAME_BITS = 32;

  // Field layout of a 32-bit frame; the neuron's receiver decodes the same offsets.
  localparam int THRESH_LSB = 20;
  localparam int THRESH_W   = 12;
  localparam int LEAK_LSB   = 12;
  localparam int LEAK_W     = 8;
  localparam int W1_LSB     = 6;
  localparam int W1_W       = 6;
  localparam int W0_LSB     = 0;
  localparam int W0_W       = 6;

  // Counter width for a 0..span-1 counter; never narrower than one bit.
  function automatic int cnt_width(input int span);
    if (span > 1) begin
      return $clog2(span);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/lif_cfg_serializer.sv
// Parallel-to-serial configuration transmitter for the dual-channel LIF neuron:
// shifts one frame MSB-first on load_mode/serial_data, then awaits params_ready.
module lif_cfg_serializer
  import lif_cfg_pkg::*;
#(
  parameter int FRAME_BITS    = DEFAULT_FRAME_BITS,
  parameter int CLKS_PER_BIT  = 1,
  parameter int READY_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  load_mode,
  output logic                  serial_data,
  input  logic                  params_ready,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int TICK_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_width(FRAME_BITS);
  localparam int WAIT_W = cnt_width(READY_TIMEOUT);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READY_TIMEOUT - 1);

  cfg_state_e            state_r, state_s;
  logic [FRAME_BITS-1:0] shreg_r, shreg_s;
  logic [TICK_W-1:0]     tick_r, tick_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic                  seen_low_r, seen_low_s;

  logic cfg_ready_r, load_mode_r, serial_data_r, busy_r, cfg_done_r, cfg_err_r;
  logic done_s, err_s, serial_data_s;

  // Next-state, counter and event logic; outputs are registered from the next state.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    tick_s     = tick_r;
    bit_s      = bit_r;
    wait_s     = wait_r;
    seen_low_s = seen_low_r;
    done_s     = 1'b0;
    err_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_r) begin
          state_s    = ST_SHIFT;
          shreg_s    = cfg_word;
          tick_s     = '0;
          bit_s      = '0;
          seen_low_s = ~params_ready;
        end else begin
          seen_low_s = seen_low_r;
        end
      end

      ST_SHIFT: begin
        seen_low_s = seen_low_r | ~params_ready;
        if (tick_r == TICK_LAST) begin
          tick_s  = '0;
          shreg_s = {shreg_r[FRAME_BITS-2:0], 1'b0};
          if (bit_r == BIT_LAST) begin
            state_s = ST_WAIT_READY;
            wait_s  = '0;
          end else begin
            bit_s = bit_r + 1'b1;
          end
        end else begin
          tick_s = tick_r + 1'b1;
        end
      end

      ST_WAIT_READY: begin
        seen_low_s = seen_low_r | ~params_ready;
        // A qualified acknowledgement takes priority over an expiring timeout.
        if (seen_low_r && params_ready) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (wait_r == WAIT_LAST) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          wait_s = wait_r + 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_s == ST_SHIFT) begin
      serial_data_s = shreg_s[FRAME_BITS-1];
    end else begin
      serial_data_s = 1'b0;
    end
  end

  // State, shift register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      tick_r     <= '0;
      bit_r      <= '0;
      wait_r     <= '0;
      seen_low_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      tick_r     <= tick_s;
      bit_r      <= bit_s;
      wait_r     <= wait_s;
      seen_low_r <= seen_low_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r   <= 1'b1;
      load_mode_r   <= 1'b0;
      serial_data_r <= 1'b0;
      busy_r        <= 1'b0;
      cfg_done_r    <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      cfg_ready_r   <= (state_s == ST_IDLE);
      load_mode_r   <= (state_s == ST_SHIFT);
      serial_data_r <= serial_data_s;
      busy_r        <= (state_s != ST_IDLE);
      cfg_done_r    <= done_s;
      cfg_err_r     <= err_s;
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign load_mode   = load_mode_r;
  assign serial_data = serial_data_r;
  assign busy        = busy_r;
  assign cfg_done    = cfg_done_r;
  assign cfg_err     = cfg_err_r;

endmodule

// File: doc/lif_cfg_serializer.md
# lif_cfg_serializer

Parallel-to-serial configuration transmitter for the dual-channel LIF neuron. It accepts one parameter frame over a valid/ready handshake and shifts it MSB-first onto the neuron's `load_mode`/`serial_data` pins. It then waits for the neuron's `params_ready` acknowledgement and reports completion or timeout. It sits on the host/test side of the neuron's serial configuration port.

## Interface
Parameters:
- `FRAME_BITS`, 32: bits per configuration frame (≥2).
- `CLKS_PER_BIT`, 1: clock cycles each bit is held (≥1).
- `READY_TIMEOUT`, 64: max cycles in WAIT_READY before error (≥1).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_word`  in  FRAME_BITS  frame to send; captured on accept.
- `cfg_valid`  in  1  frame request.
- `cfg_ready`  out  1  high only in IDLE; accept = `cfg_valid & cfg_ready`.
- `load_mode`  out  1  high for exactly FRAME_BITS×CLKS_PER_BIT cycles per frame.
- `serial_data`  out  1  current frame bit while `load_mode` is high, else 0.
- `params_ready`  in  1  neuron acknowledgement.
- `busy`  out  1  high in any state other than IDLE.
- `cfg_done`  out  1  one-cycle pulse on successful acknowledgement.
- `cfg_err`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, SHIFT, WAIT_READY. All outputs are registered.
- **IDLE**
  - `cfg_ready`=1, `load_mode`=0, `serial_data`=0.
  - On accept: capture `cfg_word` into the shift register, clear `bit_cnt`, `tick_cnt` and `seen_low`, go to SHIFT.
  - `cfg_valid` in any other state is ignored; the frame is not queued.
- **SHIFT**
  - `load_mode`=1; `serial_data` = shift-register MSB.
  - `tick_cnt` counts 0..CLKS_PER_BIT-1. At terminal count, shift left by one and increment `bit_cnt`.
  - After bit index FRAME_BITS-1 completes its period, go to WAIT_READY with `load_mode`=0 and `serial_data`=0.
- **Stale-ready qualification:** `seen_low` is set on any cycle from accept onward in which `params_ready` is sampled 0.
- **WAIT_READY**
  - A timeout counter counts from 0.
  - Cycle with `seen_low`=1 and `params_ready`=1: pulse `cfg_done` and go to IDLE.
  - Counter reaches READY_TIMEOUT-1 without that condition: pulse `cfg_err` and go to IDLE. If both conditions hold in the same cycle, done wins and `cfg_err` stays 0.
- Counter widths are `$clog2` of their range, with a minimum of 1 bit. No counter wraps: every counter is cleared on state entry.
- **Reset:** asserting `rst_n` low mid-frame immediately forces IDLE and drives `load_mode`, `serial_data`, `busy`, `cfg_done` and `cfg_err` to 0. The partial frame is discarded.

## Timing
- Reset values: `cfg_ready`=1; all other outputs 0.
- Accept at edge N → `load_mode`=1 with bit FRAME_BITS-1 on `serial_data` from edge N+1.
- Bit k (MSB = FRAME_BITS-1) is valid from edge N+1+(FRAME_BITS-1-k)×CLKS_PER_BIT for CLKS_PER_BIT cycles.
- `load_mode` falls at edge N+1+FRAME_BITS×CLKS_PER_BIT; WAIT_READY starts at that edge.
- Qualified `params_ready` sampled at edge M → `cfg_done` high M+1..M+2 and `cfg_ready` high from M+1. The earliest next accept is at edge M+1.
- Timeout: `cfg_err` pulses READY_TIMEOUT cycles after WAIT_READY entry.
- Back-to-back frames: the minimum gap between `load_mode` frames is 2 cycles of `load_mode`=0.

## Structure
- Shared package `lif_cfg_pkg`:
  - state enum (IDLE, SHIFT, WAIT_READY);
  - default frame width 32;
  - field offsets within the frame, shared with the neuron's configuration receiver.
- Single module with counters inline. A sub-module is not warranted.

## Test plan
- FRAME_BITS=32, CLKS_PER_BIT=1; send 0xA5C30F81; `params_ready` low during the frame, high 3 cycles after `load_mode` falls → serial stream 1010_0101_1100_0011_0000_1111_1000_0001 over 32 cycles, then `cfg_done` pulses once 4 cycles after `load_mode` falls.
- CLKS_PER_BIT=3; send 0x80000001 → each bit held 3 cycles, `load_mode` high for 96 cycles, `serial_data`=1 only in cycles 1–3 and 94–96.
- `params_ready` held high throughout (stale, never low) → no `cfg_done`; `cfg_err` pulses 64 cycles after WAIT_READY entry.
- `cfg_valid` pulsed mid-SHIFT with 0xFFFFFFFF → ignored; the in-flight frame is unchanged and `cfg_ready`=0 throughout.
- `rst_n` low at bit 10 of a frame → `load_mode`, `serial_data` and `busy` go to 0 asynchronously. After release, `cfg_ready`=1, and a new 0x12345678 frame shifts correctly.
- `seen_low` set and `params_ready` rising on the timeout's final cycle → `cfg_done`=1, `cfg_err`=0.
